// File: rtl/seq_unrotator_4bit.sv
// seq_unrotator_4bit
//
// Receive-side inverse of the 4-bit barrel rotator. The forward rotator
// rotates a word right by s; this block takes that rotated word together
// with the same s and rotates it back left, one position per clock, so the
// pair round-trips any 4-bit word.
//
// Ports:
//   i_clk    rising-edge clock, the only clock
//   i_rst    synchronous active-high reset
//   i_start  request, sampled only while o_ready is high
//   i_d_in   rotated word, captured with i_start
//   i_s      rotation amount used by the forward rotator, captured with i_start
//   o_ready  high while idle, the block accepts i_start
//   o_busy   high while rotating
//   o_done   one-cycle pulse, o_q holds the restored word in this cycle
//   o_q      working/result register (shows intermediate rotations while busy)

module seq_unrotator_4bit #(
    parameter int WIDTH = 4,
    parameter int SW    = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_d_in,
    input  logic [SW-1:0]    i_s,
    output logic             o_ready,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_q
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [SW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_q;

    // State register. Reset wins over everything, so an operation caught
    // mid-rotation is simply dropped without a done pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode. A zero rotation needs no shifting and goes straight
    // to DONE; otherwise SHIFT runs until the counter reaches its last step.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    if (i_s == SW'(0)) begin
                        w_next_state = DONE;
                    end else begin
                        w_next_state = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (r_cnt == SW'(1)) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Datapath. The word and amount are captured only on an accepted start;
    // each SHIFT edge rotates left by one and counts down. The counter never
    // wraps because SHIFT is only entered with a non-zero amount. Outside
    // these cases the result simply holds until the next accepted start.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q   <= '0;
            r_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_q   <= i_d_in;
                        r_cnt <= i_s;
                    end
                end
                SHIFT: begin
                    r_q   <= {r_q[WIDTH-2:0], r_q[WIDTH-1]};
                    r_cnt <= r_cnt - SW'(1);
                end
                default: begin
                    r_q   <= r_q;
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    // Handshake outputs are pure state decodes, so nothing on the inputs can
    // reach an output combinationally and the three flags are exclusive.
    always_comb begin
        o_ready = (r_state == IDLE);
        o_busy  = (r_state == SHIFT);
        o_done  = (r_state == DONE);
        o_q     = r_q;
    end

endmodule

// File: tb/tb_seq_unrotator_4bit.sv
// tb_seq_unrotator_4bit
//
// Self-checking bench for seq_unrotator_4bit. A transaction-level model
// tracks each accepted operation by its age in cycles and predicts every
// output from that age; a compare process checks the DUT against it on every
// falling edge. Directed operations additionally pin results to literals.

module tb_seq_unrotator_4bit;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] dIn;
    logic [1:0] sIn;
    logic       ready;
    logic       busy;
    logic       done;
    logic [3:0] q;

    int nChecks = 0;
    int nFails  = 0;

    // Model state: one in-flight operation described by its operands and
    // the number of edges since it was accepted.
    bit         mActive = 1'b0;
    int         mAge    = 0;
    logic [3:0] mD      = 4'b0000;
    int         mS      = 0;
    logic [3:0] mHold   = 4'b0000;
    int         cycle   = 0;
    int         lastAccept = 0;
    int         lastS   = 0;
    int         b2bCount = 0;
    bit         b2bMode = 1'b0;
    int         doneCount = 0;

    seq_unrotator_4bit dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_start (start),
        .i_d_in  (dIn),
        .i_s     (sIn),
        .o_ready (ready),
        .o_busy  (busy),
        .o_done  (done),
        .o_q     (q)
    );

    always #5 clk = ~clk;

    // Rotate left by n as plain arithmetic on a wider integer.
    function automatic logic [3:0] rotl(input logic [3:0] x, input int n);
        int v;
        v = int'(x);
        v = (v << n) | (v >> (4 - n));
        return 4'(v);
    endfunction

    // Forward barrel rotator: output bit i takes input bit (i+n) mod 4.
    function automatic logic [3:0] rotr(input logic [3:0] w, input int n);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = w[(i + n) % 4];
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Model update on each rising edge. An operation lives for s+1 cycles
    // after acceptance (s shifting cycles plus the done cycle), then the
    // block is idle again and holds the fully restored word.
    always @(posedge clk) begin
        cycle++;
        if (!b2bMode) b2bCount = 0;
        if (rst) begin
            mActive = 1'b0;
            mHold   = 4'b0000;
        end else if (mActive) begin
            mAge++;
            if (mAge > mS) begin
                mActive = 1'b0;
                mHold   = rotl(mD, mS);
            end
        end else if (start) begin
            if (b2bMode && b2bCount > 0)
                checkOutput("b2bSpacing", cycle - lastAccept, lastS + 2);
            mActive    = 1'b1;
            mAge       = 0;
            mD         = dIn;
            mS         = int'(sIn);
            lastAccept = cycle;
            lastS      = int'(sIn);
            b2bCount++;
        end
    end

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        checkOutput("ready", ready, !mActive);
        checkOutput("busy",  busy,  mActive && (mAge < mS));
        checkOutput("done",  done,  mActive && (mAge == mS));
        checkOutput("q",     q,     mActive ? rotl(mD, mAge) : mHold);
        if (done) doneCount++;
    end

    task automatic waitReady();
        int n;
        n = 0;
        while (!ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!ready) checkOutput("readyTimeout", ready, 1);
    endtask

    // Run one operation and check its done latency and result literally.
    task automatic applyStimulus(input logic [3:0] d, input logic [1:0] sh,
                                 input logic [3:0] expQ, input string tag);
        int lat;
        bit seen;
        waitReady();
        start = 1'b1;
        dIn   = d;
        sIn   = sh;
        @(negedge clk);
        start = 1'b0;
        dIn   = 4'($urandom);
        sIn   = 2'($urandom);
        lat   = 1;
        seen  = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            lat++;
        end
        checkOutput({tag, "_latency"}, seen ? lat : 0, int'(sh) + 1);
        checkOutput({tag, "_q"}, q, expQ);
    endtask

    initial begin
        int snap;

        // Reset held two cycles, with a start request during the first.
        rst   = 1'b1;
        start = 1'b1;
        dIn   = 4'b1111;
        sIn   = 2'd1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checkOutput("rst_ready", ready, 1);
        checkOutput("rst_busy",  busy,  0);
        checkOutput("rst_done",  done,  0);
        checkOutput("rst_q",     q,     4'b0000);
        rst = 1'b0;
        @(negedge clk);

        // One operation per rotation amount.
        applyStimulus(4'b0110, 2'd1, 4'b1100, "s1");
        applyStimulus(4'b1001, 2'd2, 4'b0110, "s2");
        applyStimulus(4'b0001, 2'd3, 4'b1000, "s3");
        applyStimulus(4'b1010, 2'd0, 4'b1010, "s0");

        // Round trip through the forward rotator for every word and amount.
        for (int w = 0; w < 16; w++)
            for (int sh = 0; sh < 4; sh++)
                applyStimulus(rotr(4'(w), sh), 2'(sh), 4'(w), "roundTrip");

        // Start pulses during SHIFT and DONE must be ignored.
        waitReady();
        start = 1'b1;
        dIn   = 4'b0011;
        sIn   = 2'd3;
        @(negedge clk);
        #1;
        snap  = doneCount;
        dIn   = 4'b1111;
        sIn   = 2'd1;
        for (int k = 0; k < 4; k++) @(negedge clk);
        start = 1'b0;
        #1;
        checkOutput("lockout_q",     q, 4'b1001);
        checkOutput("lockout_dones", doneCount - snap, 1);
        checkOutput("lockout_ready", ready, 1);
        @(negedge clk);
        checkOutput("lockout_noAccept", ready, 1);

        // Reset on the second shifting edge abandons the operation.
        waitReady();
        start = 1'b1;
        dIn   = 4'b1011;
        sIn   = 2'd3;
        @(negedge clk);
        start = 1'b0;
        #1;
        snap  = doneCount;
        @(negedge clk);
        rst   = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        #1;
        checkOutput("midRst_ready", ready, 1);
        checkOutput("midRst_busy",  busy,  0);
        checkOutput("midRst_done",  done,  0);
        checkOutput("midRst_q",     q,     4'b0000);
        for (int k = 0; k < 4; k++) @(negedge clk);
        #1;
        checkOutput("midRst_noDone", doneCount - snap, 0);

        // Back-to-back: start held high while operands change every cycle.
        waitReady();
        b2bMode = 1'b1;
        start   = 1'b1;
        for (int k = 0; k < 120; k++) begin
            dIn = 4'($urandom);
            sIn = 2'($urandom);
            @(negedge clk);
        end
        start   = 1'b0;
        b2bMode = 1'b0;

        // Random traffic with occasional resets.
        for (int k = 0; k < 1500; k++) begin
            rst   = ($urandom_range(0, 99) == 0);
            start = ($urandom_range(0, 2) == 0);
            dIn   = 4'($urandom);
            sIn   = 2'($urandom);
            @(negedge clk);
        end
        rst   = 1'b0;
        start = 1'b0;
        repeat (6) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/seq_unrotator_4bit.md
# seq_unrotator_4bit

Sequential inverse of the 4-bit barrel rotator. The rotator maps bit i of its output to input bit (i+S) mod 4, which is a rotate-right by S. This block takes such a rotated word plus the same S and restores the original word by rotating left one position per clock, under a start/ready/done handshake. It sits on the receive side of a rotate path, so a rotator followed by this block round-trips any 4-bit word.

## Interface
- WIDTH, 4, data width; fixed at 4 for this revision.
- SW, 2, shift-amount width, equal to log2(WIDTH).
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset, sampled on the clk rising edge.
- start  input  1  request; sampled only while ready=1.
- d_in  input  4  rotated word, bit 0 = LSB; captured with start.
- s  input  2  rotation amount used by the forward rotator; captured with start.
- ready  output  1  high in IDLE; the block accepts start.
- busy  output  1  high in SHIFT.
- done  output  1  one-cycle pulse; q is valid in this cycle.
- q  output  4  working/result register.

## Operation
- FSM states: IDLE, SHIFT, DONE. All outputs are registered or decoded from state only. No input-to-output combinational path.
- IDLE:
  - ready=1, busy=0, done=0.
  - On start=1: q<=d_in and cnt<=s.
  - Next state is DONE if s==0, otherwise SHIFT.
- SHIFT:
  - Each edge: q<={q[2:0],q[3]} (q_i <= q_(i-1 mod 4)) and cnt<=cnt-1.
  - When cnt==1 on that edge, next state is DONE; otherwise stay in SHIFT.
- DONE: done=1 for exactly one cycle. Next state is IDLE unconditionally.
- Result: after completion, q_i = d_in_((i-s) mod 4), i.e. d_in rotated left by s.
- q holds its value through IDLE until the next accepted start. q shows intermediate rotations while busy=1.
- start is ignored in SHIFT and DONE. It is not queued. d_in and s are don't-care outside the accepting edge.
- cnt is a 2-bit down counter. It never wraps, because SHIFT is entered only with cnt in 1..3.

## Timing
- Reset values: state=IDLE, ready=1, busy=0, done=0, q=4'b0000, cnt=0.
- rst takes priority over every other input on the same edge, including mid-SHIFT and in DONE. An in-flight operation is abandoned with no done pulse.
- Latency: start is accepted at edge E0.
  - done is high in the cycle after edge E_s, i.e. s+1 cycles after acceptance.
  - ready returns at edge E_(s+1).
- s=0: DONE directly after E0; done is high in the cycle after E0 with q=d_in.
- Throughput: one operation every s+2 cycles. start held high continuously is accepted at the first IDLE cycle after DONE.
- busy and ready are never both high. done is never high together with busy or ready.

## Test plan
- Reset: hold rst for 2 cycles, including one cycle with start=1 -> ready=1, busy=0, done=0, q=0000, and nothing accepted.
- Per-amount check:
  - d_in=0110, s=1 -> done in cycle 2 after accept, q=1100.
  - d_in=1001, s=2 -> q=0110.
  - d_in=0001, s=3 -> q=1000, done in cycle 4.
  - d_in=1010, s=0 -> done in cycle 1, q=1010.
- Round trip: for all 16 words x 4 amounts, feed the barrel-rotator output into this block with the same s -> q equals the original word every time.
- Busy lockout: accept d_in=0011, s=3, then pulse start with d_in=1111, s=1 during SHIFT and during DONE -> final q=1001 (0011 rotated left by 3). Exactly one done pulse. Next start is accepted only after ready=1.
- Reset mid-op: accept s=3, assert rst on the 2nd SHIFT edge -> next cycle shows IDLE reset values (ready=1, busy=0, done=0, q=0000) and no done pulse.
- Back-to-back: hold start=1 with changing d_in/s -> acceptances are spaced exactly s+2 cycles apart, and each done matches its own operands.
